// File: rtl/hilo_muldiv_if.sv
// Operation request/response bundle of the HI/LO multiply-divide unit.
// The master issues start/op/operands and reads busy/done/HI/LO back.
interface hilo_muldiv_if #(
    parameter int W = 32
);
    // start is taken only while busy is low and flush is low.
    // done pulses for exactly one cycle, in the first cycle HI/LO show the new result.
    logic         flush;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic [1:0]   dbg_state;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, hi_o, lo_o, dbg_state
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, hi_o, lo_o, dbg_state
    );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register unit: single-cycle multiply and MT writes, plus a W-cycle
// restoring divider with a final sign-fixup cycle. Flush or reset aborts a divide.
module hilo_muldiv #(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic         qneg_q, qneg_d;
    logic         rneg_q, rneg_d;
    logic         done_q, done_d;

    logic           accept;
    logic           a_neg, b_neg;
    logic [2*W-1:0] ext_a, ext_b, prod;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     trial;
    logic [W-1:0]   quo_fix, rem_fix;

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;
    assign bus.dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;

        accept = bus.start && !bus.busy && !bus.flush && (bus.op <= OP_MTLO);

        // op[0]==0 selects the signed flavour for both MULT and DIV.
        a_neg = !bus.op[0] && bus.a[W-1];
        b_neg = !bus.op[0] && bus.b[W-1];

        // Low 2W bits of the product of extended operands equal the true product.
        ext_a = a_neg ? {{W{1'b1}}, bus.a} : {{W{1'b0}}, bus.a};
        ext_b = b_neg ? {{W{1'b1}}, bus.b} : {{W{1'b0}}, bus.b};
        prod  = ext_a * ext_b;

        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;

        trial   = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
        quo_fix = qneg_q ? -quo_q : quo_q;
        rem_fix = rneg_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            hi_d   = prod[2*W-1:W];
                            lo_d   = prod[W-1:0];
                            done_d = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            rem_d   = '0;
                            cnt_d   = '0;
                            state_d = S_DIV;
                            // A zero divisor keeps the raw dividend so the remainder comes out as a.
                            if (bus.b == '0) begin
                                quo_d  = bus.a;
                                dvs_d  = '0;
                                qneg_d = 1'b0;
                                rneg_d = 1'b0;
                            end else begin
                                quo_d  = a_mag;
                                dvs_d  = b_mag;
                                qneg_d = a_neg ^ b_neg;
                                rneg_d = a_neg;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    // quo_q doubles as the dividend shift register, MSB consumed first.
                    if (!trial[W]) begin
                        rem_d = trial[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[W-2:0], quo_q[W-1]};
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    lo_d   = quo_fix;
                    hi_d   = rem_fix;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO register unit with an integrated multiplier and an iterative divider. It sits in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations through a start/busy/done handshake and holds the architectural HI and LO registers. It supports pipeline flush, which aborts an in-flight divide without touching HI/LO.

## Interface
Parameters:
- W, 32, data width of operands, HI and LO (even, ≥ 4)
- CW, $clog2(W)+1, width of the internal divide iteration counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort in-flight divide; suppress same-cycle start
- start  in  1  operation request, sampled every cycle
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (ignored)
- a  in  W  operand A (dividend, multiplicand, MT source)
- b  in  W  operand B (divisor, multiplier)
- busy  out  1  divide in progress; start ignored while high
- done  out  1  one-cycle pulse: HI/LO updated by the accepted operation
- hi_o  out  W  HI register
- lo_o  out  W  LO register

## Operation
- Reset values: hi_o=0, lo_o=0, busy=0, done=0, state IDLE, counter 0. rst overrides every other input.
- Accept condition: start & !busy & !flush & op≤5. Any start not meeting this condition is dropped silently, with no queuing.
- States: IDLE, DIV (iterating), FIN (writeback of the divide result).
- MULT/MULTU:
  - 2W-bit product, signed or unsigned.
  - hi_o ← product[2W-1:W], lo_o ← product[W-1:0] at the accepting edge.
  - State stays IDLE.
- MTHI / MTLO:
  - hi_o ← a (MTHI) or lo_o ← a (MTLO) at the accepting edge.
  - The other register is unchanged.
- DIV/DIVU:
  - Latch operands on accept. For signed ops, latch magnitudes plus sign flags qneg=a[W-1]^b[W-1] and rneg=a[W-1].
  - Go IDLE→DIV; run W restoring iterations, one quotient bit per cycle, MSB first.
  - After the last iteration go DIV→FIN.
  - In FIN: apply signs, write lo_o ← quotient and hi_o ← remainder, then return to IDLE.
- Signed rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/−1 yields quotient=MIN, remainder=0 (two's-complement wrap, no trap).
- Divide by zero:
  - Takes the full latency.
  - lo_o ← all ones, hi_o ← a as latched (raw, unsigned interpretation), for both DIV and DIVU.
- flush while busy:
  - State → IDLE, busy=0 from the next cycle.
  - No HI/LO write, no done pulse.
  - flush in IDLE has no effect except blocking that cycle's start.
- Reserved op codes: no state change, no done.

## Timing
- Accept in cycle N; all latencies below are relative to N.
- MULT/MULTU/MTHI/MTLO:
  - hi_o/lo_o show the new value from cycle N+1.
  - done=1 in cycle N+1 only.
  - busy stays 0, so back-to-back accepts are legal every cycle.
- DIV/DIVU:
  - busy=1 in cycles N+1 … N+W+1 (W iterations plus FIN).
  - hi_o/lo_o updated at the edge ending cycle N+W+1.
  - done=1 in cycle N+W+2.
  - busy=0 in cycle N+W+2, so a new start is accepted in that cycle.
- Total divide latency is W+2 cycles from accept to done (34 at W=32).
- Reads of hi_o/lo_o during a divide return the old values. The pipeline must stall MFHI/MFLO on busy.
- flush in cycle M, with N<M≤N+W+1: busy=0 in M+1, HI/LO retain their pre-divide values, no done.
- Synchronous rst in the middle of a divide: all outputs reach reset values in the next cycle, and no pending writeback occurs.

## Test plan
- Reset: after rst, expect hi_o=0, lo_o=0, busy=0, done=0. Then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 on consecutive cycles → hi_o=0x12345678, lo_o=0x9ABCDEF0, with a done pulse each.
- Multiply, W=32:
  - MULT a=0xFFFFFFFF(−1), b=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, done at N+1.
  - MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- Divide, W=32:
  - DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD(−3), hi=0xFFFFFFFF(−1).
  - DIVU a=100, b=7 → lo=14, hi=2.
  - For both, busy high for exactly 33 cycles and done in cycle N+34.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- Handshake:
  - start MULT during busy → ignored, HI/LO unchanged.
  - start in the same cycle done is high → accepted.
- Abort:
  - flush at N+10 of a DIVU → busy=0 at N+11, no done, HI/LO unchanged.
  - rst at N+20 of a DIV → all outputs zero, no later writeback.
